// File: rtl/id_rob_tracker_pkg.sv
// Shared types and helpers for the in-order ID tracker.
package id_rob_tracker_pkg;

    localparam int DEF_LOG2_IDS      = 3;
    localparam int DEF_RETIRE_PORTS  = 2;
    localparam int DEF_WB_PORTS      = 2;
    localparam int DEF_MAX_RD_RETIRE = 1;
    localparam int DEF_PHYS_W        = 6;

    // Wide enough for any supported ID width; callers zero-extend and mask.
    localparam int AGE_W = 8;

    // Age of an ID relative to the head, modulo the ID space given by mask.
    function automatic logic [AGE_W-1:0] id_age(input logic [AGE_W-1:0] id,
                                                input logic [AGE_W-1:0] head,
                                                input logic [AGE_W-1:0] mask);
        return (id - head) & mask;
    endfunction

endpackage

// File: rtl/id_rob_if.sv
// Issue / writeback / retire bundle between the pipeline and the ID tracker.
interface id_rob_if
    import id_rob_tracker_pkg::*;
#(
    parameter int LOG2_IDS      = DEF_LOG2_IDS,
    parameter int RETIRE_PORTS  = DEF_RETIRE_PORTS,
    parameter int WB_PORTS      = DEF_WB_PORTS,
    parameter int MAX_RD_RETIRE = DEF_MAX_RD_RETIRE,
    parameter int PHYS_W        = DEF_PHYS_W
);
    localparam int CNT_W = $clog2(RETIRE_PORTS + 1);

    logic                              issue_valid;
    logic                              issue_ready;
    logic [LOG2_IDS-1:0]               issue_id;
    logic                              issue_uses_rd;
    logic [PHYS_W-1:0]                 issue_phys_rd;
    logic                              issue_multicycle;
    logic [WB_PORTS-1:0]               wb_valid;
    logic [WB_PORTS*LOG2_IDS-1:0]      wb_id;
    logic                              retire_hold;
    logic                              exception_pending;
    logic                              squash_valid;
    logic [LOG2_IDS-1:0]               squash_id;
    logic [RETIRE_PORTS-1:0]           retire_port_valid;
    logic [RETIRE_PORTS*LOG2_IDS-1:0]  retire_ids;
    logic [CNT_W-1:0]                  retire_count;
    logic [MAX_RD_RETIRE-1:0]          retire_rd_valid;
    logic [MAX_RD_RETIRE*PHYS_W-1:0]   retire_phys_rd;
    logic [LOG2_IDS:0]                 inflight_count;

    modport master (
        output issue_valid, issue_uses_rd, issue_phys_rd, issue_multicycle,
        output wb_valid, wb_id, retire_hold, exception_pending, squash_valid, squash_id,
        input  issue_ready, issue_id, retire_port_valid, retire_ids, retire_count,
        input  retire_rd_valid, retire_phys_rd, inflight_count
    );

    modport slave (
        input  issue_valid, issue_uses_rd, issue_phys_rd, issue_multicycle,
        input  wb_valid, wb_id, retire_hold, exception_pending, squash_valid, squash_id,
        output issue_ready, issue_id, retire_port_valid, retire_ids, retire_count,
        output retire_rd_valid, retire_phys_rd, inflight_count
    );

endinterface

// File: rtl/id_rob_retire_select.sv
// Contiguous retire selector: takes eligible candidates in age order, stopping
// at the first one that is not eligible or would exceed the rd-write budget.
module id_rob_retire_select #(
    parameter int RETIRE_PORTS  = 2,
    parameter int MAX_RD_RETIRE = 1,
    parameter int IDX_W         = 1
) (
    input  logic [RETIRE_PORTS-1:0]         eligible,
    input  logic [RETIRE_PORTS-1:0]         uses_rd,
    output logic [RETIRE_PORTS-1:0]         port_valid,
    output logic [MAX_RD_RETIRE-1:0]        slot_valid,
    output logic [MAX_RD_RETIRE*IDX_W-1:0]  slot_idx
);

    int   rd_cnt;
    logic run;

    always_comb begin
        port_valid = '0;
        slot_valid = '0;
        slot_idx   = '0;
        rd_cnt     = 0;
        run        = 1'b1;
        for (int i = 0; i < RETIRE_PORTS; i++) begin
            if (run && eligible[i] && (!uses_rd[i] || rd_cnt < MAX_RD_RETIRE)) begin
                port_valid[i] = 1'b1;
                if (uses_rd[i]) begin
                    for (int k = 0; k < MAX_RD_RETIRE; k++) begin
                        if (k == rd_cnt) begin
                            slot_valid[k]                = 1'b1;
                            slot_idx[k*IDX_W +: IDX_W]   = IDX_W'(i);
                        end
                    end
                    rd_cnt = rd_cnt + 1;
                end
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/id_rob_tracker.sv
// In-order instruction-ID tracker: allocates at issue, marks completion from
// writeback ports, retires contiguous done IDs and supports younger-ID squash.
module id_rob_tracker
    import id_rob_tracker_pkg::*;
#(
    parameter int LOG2_IDS      = DEF_LOG2_IDS,
    parameter int RETIRE_PORTS  = DEF_RETIRE_PORTS,
    parameter int WB_PORTS      = DEF_WB_PORTS,
    parameter int MAX_RD_RETIRE = DEF_MAX_RD_RETIRE,
    parameter int PHYS_W        = DEF_PHYS_W
) (
    input  logic     clk,
    input  logic     rst_n,
    id_rob_if.slave  bus
);

    localparam int NUM_IDS = 2 ** LOG2_IDS;
    localparam int PTR_W   = LOG2_IDS + 1;
    localparam int CNT_W   = $clog2(RETIRE_PORTS + 1);
    localparam int IDX_W   = (RETIRE_PORTS > 1) ? $clog2(RETIRE_PORTS) : 1;

    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d, count;
    logic [NUM_IDS-1:0] done_q, done_d, uses_rd_q, uses_rd_d;
    logic [PHYS_W-1:0]  phys_ram [NUM_IDS];
    logic               full, issue_fire;
    logic [LOG2_IDS-1:0] tail_idx;

    logic [RETIRE_PORTS-1:0]           port_valid_q, port_valid_d;
    logic [RETIRE_PORTS*LOG2_IDS-1:0]  ids_q, ids_d;
    logic [CNT_W-1:0]                  count_q, count_d, sel_count;
    logic [MAX_RD_RETIRE-1:0]          rd_valid_q, rd_valid_d;
    logic [MAX_RD_RETIRE*PHYS_W-1:0]   phys_q, phys_d;
    logic [PTR_W-1:0]                  inflight_q, inflight_d;

    assign count      = tail_q - head_q;
    assign full       = (count == PTR_W'(NUM_IDS));
    assign tail_idx   = tail_q[LOG2_IDS-1:0];
    assign issue_fire = bus.issue_valid & bus.issue_ready;

    assign bus.issue_ready = ~full & ~bus.squash_valid;
    assign bus.issue_id    = tail_idx;

    logic [LOG2_IDS-1:0]      cand_idx  [RETIRE_PORTS];
    logic [PHYS_W-1:0]        cand_phys [RETIRE_PORTS];
    logic [RETIRE_PORTS-1:0]  cand_eligible, cand_uses_rd, port_valid;
    logic [MAX_RD_RETIRE-1:0] slot_valid;
    logic [MAX_RD_RETIRE*IDX_W-1:0] slot_idx;

    // Candidate i is the ID at head+i; contiguity is enforced by the selector.
    generate
        for (genvar gi = 0; gi < RETIRE_PORTS; gi++) begin : g_cand
            assign cand_idx[gi]      = head_q[LOG2_IDS-1:0] + LOG2_IDS'(gi);
            assign cand_eligible[gi] = (PTR_W'(gi) < count) & done_q[cand_idx[gi]] &
                                       ~bus.retire_hold & (~bus.exception_pending | (gi == 0));
            assign cand_uses_rd[gi]  = uses_rd_q[cand_idx[gi]];
            assign cand_phys[gi]     = phys_ram[cand_idx[gi]];
        end
    endgenerate

    id_rob_retire_select #(
        .RETIRE_PORTS  (RETIRE_PORTS),
        .MAX_RD_RETIRE (MAX_RD_RETIRE),
        .IDX_W         (IDX_W)
    ) u_select (
        .eligible   (cand_eligible),
        .uses_rd    (cand_uses_rd),
        .port_valid (port_valid),
        .slot_valid (slot_valid),
        .slot_idx   (slot_idx)
    );

    always_comb begin
        sel_count = '0;
        for (int i = 0; i < RETIRE_PORTS; i++) begin
            sel_count = sel_count + CNT_W'(port_valid[i]);
        end
    end

    // Issue is written after writeback so a same-index issue overrides a stale wb.
    always_comb begin
        head_d    = head_q + PTR_W'(sel_count);
        tail_d    = tail_q;
        done_d    = done_q;
        uses_rd_d = uses_rd_q;
        for (int w = 0; w < WB_PORTS; w++) begin
            if (bus.wb_valid[w]) begin
                done_d[bus.wb_id[w*LOG2_IDS +: LOG2_IDS]] = 1'b1;
            end
        end
        if (issue_fire) begin
            done_d[tail_idx]    = ~bus.issue_multicycle;
            uses_rd_d[tail_idx] = bus.issue_uses_rd;
            tail_d              = tail_q + PTR_W'(1);
        end
        if (bus.squash_valid) begin
            tail_d = head_q + PTR_W'(id_age(AGE_W'(bus.squash_id), AGE_W'(head_q[LOG2_IDS-1:0]),
                                            AGE_W'(NUM_IDS - 1))) + PTR_W'(1);
        end
    end

    always_comb begin
        port_valid_d = port_valid;
        count_d      = sel_count;
        rd_valid_d   = slot_valid;
        ids_d        = '0;
        phys_d       = '0;
        for (int i = 0; i < RETIRE_PORTS; i++) begin
            if (port_valid[i]) begin
                ids_d[i*LOG2_IDS +: LOG2_IDS] = cand_idx[i];
            end
        end
        for (int k = 0; k < MAX_RD_RETIRE; k++) begin
            if (slot_valid[k]) begin
                phys_d[k*PHYS_W +: PHYS_W] = cand_phys[slot_idx[k*IDX_W +: IDX_W]];
            end
        end
        inflight_d = tail_d - head_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q       <= '0;
            tail_q       <= '0;
            done_q       <= '0;
            uses_rd_q    <= '0;
            port_valid_q <= '0;
            ids_q        <= '0;
            count_q      <= '0;
            rd_valid_q   <= '0;
            phys_q       <= '0;
            inflight_q   <= '0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            done_q       <= done_d;
            uses_rd_q    <= uses_rd_d;
            port_valid_q <= port_valid_d;
            ids_q        <= ids_d;
            count_q      <= count_d;
            rd_valid_q   <= rd_valid_d;
            phys_q       <= phys_d;
            inflight_q   <= inflight_d;
        end
    end

    always_ff @(posedge clk) begin
        if (issue_fire) begin
            phys_ram[tail_idx] <= bus.issue_phys_rd;
        end
    end

    assign bus.retire_port_valid = port_valid_q;
    assign bus.retire_ids        = ids_q;
    assign bus.retire_count      = count_q;
    assign bus.retire_rd_valid   = rd_valid_q;
    assign bus.retire_phys_rd    = phys_q;
    assign bus.inflight_count    = inflight_q;

    a_squash_inflight: assert property (@(posedge clk) disable iff (!rst_n)
        bus.squash_valid |-> (count != '0));

    generate
        for (genvar gi = 0; gi < WB_PORTS; gi++) begin : g_wb_chk
            a_wb_inflight: assert property (@(posedge clk) disable iff (!rst_n)
                bus.wb_valid[gi] |-> (PTR_W'(id_age(AGE_W'(bus.wb_id[gi*LOG2_IDS +: LOG2_IDS]),
                                                   AGE_W'(head_q[LOG2_IDS-1:0]),
                                                   AGE_W'(NUM_IDS - 1))) < count));
        end
    endgenerate

endmodule

// File: tb/tb_id_rob_tracker.sv
// Directed bench for id_rob_tracker with a queue-based reference model checked every cycle.
module tb_id_rob_tracker;

    localparam int L  = 3;
    localparam int RP = 2;
    localparam int WP = 2;
    localparam int MR = 1;
    localparam int PW = 6;
    localparam int N  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    id_rob_if #(.LOG2_IDS(L), .RETIRE_PORTS(RP), .WB_PORTS(WP),
                .MAX_RD_RETIRE(MR), .PHYS_W(PW)) bus ();

    id_rob_tracker #(.LOG2_IDS(L), .RETIRE_PORTS(RP), .WB_PORTS(WP),
                     .MAX_RD_RETIRE(MR), .PHYS_W(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        bit uses_rd;
        int phys;
        bit done;
    } ent_t;

    ent_t q[$];
    int   head_id;
    int   checks = 0;
    int   errors = 0;
    bit   in_step = 1'b0;

    int exp_ready, exp_issue_id;
    int cur_pv, cur_cnt, cur_rdv, cur_infl;
    int cur_ids [RP];
    int cur_phys[MR];
    int nxt_pv, nxt_cnt, nxt_rdv, nxt_infl;
    int nxt_ids [RP];
    int nxt_phys[MR];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_idle();
        bus.issue_valid       = 1'b0;
        bus.issue_uses_rd     = 1'b0;
        bus.issue_phys_rd     = '0;
        bus.issue_multicycle  = 1'b0;
        bus.wb_valid          = '0;
        bus.wb_id             = '0;
        bus.retire_hold       = 1'b0;
        bus.exception_pending = 1'b0;
        bus.squash_valid      = 1'b0;
        bus.squash_id         = '0;
    endtask

    task automatic model_clear();
        q.delete();
        head_id  = 0;
        cur_pv   = 0;
        cur_cnt  = 0;
        cur_rdv  = 0;
        cur_infl = 0;
        cur_ids  = '{default: 0};
        cur_phys = '{default: 0};
    endtask

    // Reference behaviour: oldest-first retire of done IDs, within port and rd budgets.
    task automatic model_eval(input bit iv, input bit urd, input int phys, input bit mc,
                              input bit [1:0] wbv, input int wb0, input int wb1,
                              input bit hold, input bit exc, input bit sqv, input int sqid);
        int   cnt, n, rd, keep, tail_id;
        ent_t e;
        cnt       = q.size();
        tail_id   = (head_id + cnt) % N;
        exp_ready = (cnt < N && !sqv) ? 1 : 0;
        exp_issue_id = tail_id;
        n = 0;
        rd = 0;
        nxt_pv = 0;
        nxt_rdv = 0;
        nxt_ids = '{default: 0};
        nxt_phys = '{default: 0};
        for (int i = 0; i < RP && i < cnt; i++) begin
            if (hold || (exc && i > 0) || !q[i].done) break;
            if (q[i].uses_rd) begin
                if (rd == MR) break;
                nxt_phys[rd] = q[i].phys;
                nxt_rdv |= (1 << rd);
                rd++;
            end
            nxt_pv |= (1 << i);
            nxt_ids[i] = q[i].id;
            n++;
        end
        nxt_cnt = n;
        foreach (q[j]) begin
            if ((wbv[0] && q[j].id == wb0) || (wbv[1] && q[j].id == wb1)) q[j].done = 1'b1;
        end
        if (sqv) begin
            keep = (((sqid - head_id) % N) + N) % N + 1;
            while (q.size() > keep) void'(q.pop_back());
        end
        repeat (n) void'(q.pop_front());
        head_id = (head_id + n) % N;
        if (iv && exp_ready == 1) begin
            e.id = tail_id;
            e.uses_rd = urd;
            e.phys = phys;
            e.done = !mc;
            q.push_back(e);
        end
        nxt_infl = q.size();
    endtask

    task automatic step(input bit iv, input bit urd, input int phys, input bit mc,
                        input bit [1:0] wbv, input int wb0, input int wb1,
                        input bit hold, input bit exc, input bit sqv, input int sqid);
        in_step = 1'b1;
        bus.issue_valid       = iv;
        bus.issue_uses_rd     = urd;
        bus.issue_phys_rd     = 6'(phys);
        bus.issue_multicycle  = mc;
        bus.wb_valid          = wbv;
        bus.wb_id             = {3'(wb1), 3'(wb0)};
        bus.retire_hold       = hold;
        bus.exception_pending = exc;
        bus.squash_valid      = sqv;
        bus.squash_id         = 3'(sqid);
        model_eval(iv, urd, phys, mc, wbv, wb0, wb1, hold, exc, sqv, sqid);
        @(posedge clk);
        #1;
        cur_pv   = nxt_pv;
        cur_cnt  = nxt_cnt;
        cur_rdv  = nxt_rdv;
        cur_infl = nxt_infl;
        cur_ids  = nxt_ids;
        cur_phys = nxt_phys;
        in_step  = 1'b0;
        set_idle();
        $display("step iv=%0d wb=%b hold=%0d exc=%0d sq=%0d -> retire_cnt=%0d inflight=%0d",
                 iv, wbv, hold, exc, sqv, bus.retire_count, bus.inflight_count);
    endtask

    task automatic idle(input int cycles, input bit hold);
        repeat (cycles) step(0, 0, 0, 0, 2'b00, 0, 0, hold, 0, 0, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_port_valid"}, int'(bus.retire_port_valid), 0);
        chk({tag, "_ids"},        int'(bus.retire_ids), 0);
        chk({tag, "_count"},      int'(bus.retire_count), 0);
        chk({tag, "_rd_valid"},   int'(bus.retire_rd_valid), 0);
        chk({tag, "_phys"},       int'(bus.retire_phys_rd), 0);
        chk({tag, "_inflight"},   int'(bus.inflight_count), 0);
        chk({tag, "_issue_id"},   int'(bus.issue_id), 0);
    endtask

    // Compare process: mid-cycle, against the model's expectations.
    always @(negedge clk) begin
        if (in_step && rst_n) begin
            chk("issue_ready", int'(bus.issue_ready), exp_ready);
            chk("issue_id", int'(bus.issue_id), exp_issue_id);
            chk("retire_port_valid", int'(bus.retire_port_valid), cur_pv);
            chk("retire_count", int'(bus.retire_count), cur_cnt);
            chk("retire_rd_valid", int'(bus.retire_rd_valid), cur_rdv);
            chk("inflight_count", int'(bus.inflight_count), cur_infl);
            for (int i = 0; i < RP; i++) begin
                if (cur_pv[i]) chk("retire_id", int'(bus.retire_ids[i*L +: L]), cur_ids[i]);
            end
            for (int k = 0; k < MR; k++) begin
                chk("retire_phys_rd", int'(bus.retire_phys_rd[k*PW +: PW]), cur_phys[k]);
            end
        end
    end

    initial begin
        set_idle();
        model_clear();
        #3;
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_ready", int'(bus.issue_ready), 1);

        // Fill all 8 IDs while retirement is held, then a 9th must stall.
        for (int i = 0; i < 8; i++) step(1, i % 2, 10 + i, 0, 2'b00, 0, 0, 1, 0, 0, 0);
        chk("full_ready", int'(bus.issue_ready), 0);
        chk("full_inflight", int'(bus.inflight_count), 8);
        step(1, 0, 30, 0, 2'b00, 0, 0, 1, 0, 0, 0);
        idle(8, 0);

        // Out-of-order completion: IDs 0-3 retire only once ID0 is done.
        for (int i = 0; i < 4; i++) step(1, 0, 20 + i, 1, 2'b00, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 2'b11, 2, 3, 0, 0, 0, 0);
        idle(1, 0);
        chk("ooo_wait_count", int'(bus.retire_count), 0);
        step(0, 0, 0, 0, 2'b11, 0, 1, 0, 0, 0, 0);
        idle(1, 0);
        chk("ooo_first_count", int'(bus.retire_count), 2);
        chk("ooo_first_id0", int'(bus.retire_ids[0 +: L]), 0);
        chk("ooo_first_id1", int'(bus.retire_ids[L +: L]), 1);
        idle(1, 0);
        chk("ooo_second_id0", int'(bus.retire_ids[0 +: L]), 2);
        chk("ooo_second_id1", int'(bus.retire_ids[L +: L]), 3);
        idle(2, 0);

        // Two rd-writers with a budget of one per cycle retire on consecutive cycles.
        step(1, 1, 40, 0, 2'b00, 0, 0, 1, 0, 0, 0);
        step(1, 1, 41, 0, 2'b00, 0, 0, 1, 0, 0, 0);
        idle(1, 0);
        chk("rdlim_first_count", int'(bus.retire_count), 1);
        chk("rdlim_first_phys", int'(bus.retire_phys_rd), 40);
        idle(1, 0);
        chk("rdlim_second_count", int'(bus.retire_count), 1);
        chk("rdlim_second_phys", int'(bus.retire_phys_rd), 41);
        idle(2, 0);

        // Asynchronous reset with IDs in flight clears outputs without a clock edge.
        for (int i = 0; i < 3; i++) step(1, 1, 50 + i, 0, 2'b00, 0, 0, 1, 0, 0, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        model_clear();
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Squash with head=2 and 6 in flight, keeping IDs up to 4.
        step(1, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        step(1, 0, 2, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        idle(2, 0);
        for (int i = 0; i < 6; i++) step(1, 1, 2 + i, 0, 2'b00, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 1, 4);
        chk("squash_inflight", int'(bus.inflight_count), 3);
        chk("squash_next_id", int'(bus.issue_id), 5);
        idle(5, 0);

        // Sustained issue/retire across the ID wrap.
        for (int i = 0; i < 20; i++) step(1, 0, i, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        idle(3, 0);

        // Exception pending limits retirement to a single port.
        step(1, 0, 60, 0, 2'b00, 0, 0, 1, 0, 0, 0);
        step(1, 0, 61, 0, 2'b00, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0);
        chk("exc_first_count", int'(bus.retire_count), 1);
        step(0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0);
        chk("exc_second_count", int'(bus.retire_count), 1);
        idle(2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
